// File: rtl/adsr_pkg.sv
// Shared types and helpers for the adsr_bank envelope generator.
// Build option: ADSR_LEGATO_EN selects legato retrigger in adsr_voice.
package adsr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

    function automatic int unsigned env_max(input int unsigned depth);
        return (32'd1 << depth) - 32'd1;
    endfunction

endpackage

// File: rtl/adsr_if.sv
// Allocator-to-envelope bundle: gates and shared controls in, envelopes out.
interface adsr_if #(
    parameter int NUM_VOICES = 4,
    parameter int WAVE_DEPTH = 8,
    parameter int RATE_WIDTH = 12
);

    logic [NUM_VOICES-1:0]            Gate;
    logic [RATE_WIDTH-1:0]            AttackRate;
    logic [RATE_WIDTH-1:0]            DecayRate;
    logic [RATE_WIDTH-1:0]            ReleaseRate;
    logic [WAVE_DEPTH-1:0]            Sustain;
    logic [NUM_VOICES*WAVE_DEPTH-1:0] Envelope;
    logic [NUM_VOICES-1:0]            Active;

    modport master (
        output Gate, AttackRate, DecayRate, ReleaseRate, Sustain,
        input  Envelope, Active
    );

    modport slave (
        input  Gate, AttackRate, DecayRate, ReleaseRate, Sustain,
        output Envelope, Active
    );

endinterface

// File: rtl/adsr_voice.sv
// One ADSR envelope channel driven by a phase-accumulator stepper.
// ADSR_LEGATO_EN: a retrigger keeps the current level instead of restarting at 0.
module adsr_voice
    import adsr_pkg::*;
#(
    parameter int WAVE_DEPTH = 8,
    parameter int RATE_WIDTH = 12
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  gate,
    input  logic [RATE_WIDTH-1:0] attack_rate,
    input  logic [RATE_WIDTH-1:0] decay_rate,
    input  logic [RATE_WIDTH-1:0] release_rate,
    input  logic [WAVE_DEPTH-1:0] sustain,
    output logic [WAVE_DEPTH-1:0] env,
    output logic                  active
);

    localparam logic [WAVE_DEPTH-1:0] ENV_MAX = WAVE_DEPTH'(env_max(WAVE_DEPTH));

    adsr_state_t           state, state_d;
    logic [RATE_WIDTH-1:0] acc, acc_d;
    logic [WAVE_DEPTH-1:0] env_d;
    logic                  gate_q;
    logic [RATE_WIDTH-1:0] rate;
    logic [RATE_WIDTH:0]   sum;
    logic                  step, rise, fall;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state  <= IDLE;
            acc    <= '0;
            env    <= '0;
            gate_q <= 1'b0;
        end else begin
            state  <= state_d;
            acc    <= acc_d;
            env    <= env_d;
            gate_q <= gate;
        end
    end

    assign active = (state != IDLE);
    assign rise   = gate & ~gate_q;
    assign fall   = ~gate & gate_q;

    always_comb begin
        rate = '0;
        unique case (state)
            ATTACK:  rate = attack_rate;
            DECAY:   rate = decay_rate;
            RELEASE: rate = release_rate;
            default: rate = '0;
        endcase
    end

    // carry out of the accumulator is the one-LSB step for this cycle
    assign sum  = {1'b0, acc} + {1'b0, rate};
    assign step = sum[RATE_WIDTH];

    always_comb begin
        state_d = state;
        acc_d   = acc;
        env_d   = env;
        if (rise) begin
            state_d = ATTACK;
            acc_d   = '0;
`ifdef ADSR_LEGATO_EN
            env_d   = env;
`else
            env_d   = '0;
`endif
        end else if (fall && (state == ATTACK || state == DECAY ||
                              state == SUSTAIN)) begin
            state_d = RELEASE;
            acc_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_d = IDLE;
                end
                ATTACK: begin
                    if (env == ENV_MAX) begin
                        state_d = DECAY;
                        acc_d   = '0;
                    end else begin
                        acc_d = sum[RATE_WIDTH-1:0];
                        if (step) env_d = env + 1'b1;
                    end
                end
                DECAY: begin
                    if (env <= sustain) begin
                        state_d = SUSTAIN;
                        env_d   = sustain;
                    end else begin
                        acc_d = sum[RATE_WIDTH-1:0];
                        if (step) env_d = env - 1'b1;
                    end
                end
                SUSTAIN: begin
                    env_d = sustain;
                end
                RELEASE: begin
                    if (env == '0) begin
                        state_d = IDLE;
                        acc_d   = '0;
                    end else begin
                        acc_d = sum[RATE_WIDTH-1:0];
                        if (step) env_d = env - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    env_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adsr_bank.sv
// Bank of independent ADSR voices sharing rate and sustain controls.
// ADSR_LEGATO_EN (see adsr_voice) selects legato retrigger behaviour.
module adsr_bank
    import adsr_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int WAVE_DEPTH = 8,
    parameter int RATE_WIDTH = 12
) (
    input logic   Clock,
    input logic   Reset,
    adsr_if.slave bus
);

    logic [NUM_VOICES*WAVE_DEPTH-1:0] env_w;
    logic [NUM_VOICES-1:0]            act_w;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        adsr_voice #(
            .WAVE_DEPTH (WAVE_DEPTH),
            .RATE_WIDTH (RATE_WIDTH)
        ) u_voice (
            .Clock        (Clock),
            .Reset        (Reset),
            .gate         (bus.Gate[v]),
            .attack_rate  (bus.AttackRate),
            .decay_rate   (bus.DecayRate),
            .release_rate (bus.ReleaseRate),
            .sustain      (bus.Sustain),
            .env          (env_w[v*WAVE_DEPTH +: WAVE_DEPTH]),
            .active       (act_w[v])
        );
    end

    assign bus.Envelope = env_w;
    assign bus.Active   = act_w;

endmodule

// File: tb/tb_adsr_bank.sv
// Scoreboard bench for adsr_bank: reference model feeds a queue, monitor compares.
module tb_adsr_bank;

    localparam int NV   = 4;
    localparam int WD   = 8;
    localparam int RW   = 8;
    localparam int EMAX = 255;
    localparam int RMOD = 256;

    localparam int P_IDLE = 0;
    localparam int P_ATK  = 1;
    localparam int P_DEC  = 2;
    localparam int P_SUS  = 3;
    localparam int P_REL  = 4;

`ifdef ADSR_LEGATO_EN
    localparam int RETRIG0 = 80;
`else
    localparam int RETRIG0 = 0;
`endif

    typedef struct {
        logic [NV*WD-1:0] env;
        logic [NV-1:0]    act;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;

    adsr_if #(.NUM_VOICES(NV), .WAVE_DEPTH(WD), .RATE_WIDTH(RW)) bus();

    adsr_bank #(
        .NUM_VOICES (NV),
        .WAVE_DEPTH (WD),
        .RATE_WIDTH (RW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    int ph[NV];
    int lv[NV];
    int fr[NV];
    bit gq[NV];

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // level moves one LSB each time the accumulated rate wraps past 2^RW
    function automatic bit advance(int v, int rate);
        fr[v] += rate;
        if (fr[v] >= RMOD) begin
            fr[v] -= RMOD;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_edge();
        for (int v = 0; v < NV; v++) begin
            bit g;
            int sus;
            g   = bus.Gate[v];
            sus = int'(bus.Sustain);
            if (!Reset) begin
                ph[v] = P_IDLE; lv[v] = 0; fr[v] = 0; gq[v] = 1'b0;
            end else begin
                if (g && !gq[v]) begin
                    ph[v] = P_ATK;
                    fr[v] = 0;
`ifndef ADSR_LEGATO_EN
                    lv[v] = 0;
`endif
                end else if (!g && gq[v] && ph[v] != P_IDLE && ph[v] != P_REL) begin
                    ph[v] = P_REL;
                    fr[v] = 0;
                end else begin
                    case (ph[v])
                        P_ATK:
                            if (lv[v] == EMAX) begin
                                ph[v] = P_DEC; fr[v] = 0;
                            end else if (advance(v, int'(bus.AttackRate))) lv[v]++;
                        P_DEC:
                            if (lv[v] <= sus) begin
                                ph[v] = P_SUS; lv[v] = sus;
                            end else if (advance(v, int'(bus.DecayRate))) lv[v]--;
                        P_SUS: lv[v] = sus;
                        P_REL:
                            if (lv[v] == 0) ph[v] = P_IDLE;
                            else if (advance(v, int'(bus.ReleaseRate))) lv[v]--;
                        default: ;
                    endcase
                end
                gq[v] = g;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.env = '0;
        e.act = '0;
        for (int v = 0; v < NV; v++) begin
            e.env[v*WD +: WD] = WD'(lv[v]);
            e.act[v] = (ph[v] != P_IDLE);
        end
        return e;
    endfunction

    task automatic cyc();
        model_edge();
        q.push_back(model_out());
        @(posedge Clock);
        #1;
    endtask

    function automatic int envv(int v);
        return int'(bus.Envelope[v*WD +: WD]);
    endfunction

    task automatic run_until(input int v, input int target, input int lim, output int n);
        n = 0;
        while (envv(v) != target && n < lim) begin
            cyc();
            n++;
        end
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("sb_envelope", bus.Envelope, e.env);
            check("sb_active", bus.Active, e.act);
        end
    end

    initial begin
        int n;
        int mx;
        Reset = 1'b0;
        bus.Gate = '0;
        bus.AttackRate = '0;
        bus.DecayRate = '0;
        bus.ReleaseRate = '0;
        bus.Sustain = '0;
        repeat (3) cyc();
        check("reset_env", bus.Envelope, 0);
        check("reset_active", bus.Active, 0);

        // full envelope on voice 0
        Reset = 1'b1;
        bus.AttackRate = 8'd128;
        bus.DecayRate = 8'd128;
        bus.ReleaseRate = 8'd64;
        bus.Sustain = 8'd100;
        bus.Gate = 4'b0001;
        cyc();
        check("rise_active", bus.Active, 4'b0001);
        check("rise_env", envv(0), 0);
        run_until(0, 255, 600, n);
        check("attack_cycles", n, 510);
        cyc();
        run_until(0, 100, 400, n);
        check("decay_cycles", n, 310);
        cyc();
        bus.Sustain = 8'd40;
        cyc();
        check("live_sustain", envv(0), 40);
        bus.Sustain = 8'd100;
        cyc();
        check("sustain_back", envv(0), 100);
        bus.Gate = 4'b0000;
        cyc();
        check("release_entry", envv(0), 100);
        run_until(0, 0, 500, n);
        check("release_cycles", n, 400);
        check("release_active_hold", bus.Active[0], 1);
        cyc();
        check("release_idle", bus.Active[0], 0);

        // early release out of attack
        bus.Gate = 4'b0001;
        cyc();
        run_until(0, 50, 200, n);
        check("early_reach50", n, 100);
        bus.Gate = 4'b0000;
        cyc();
        check("early_fall_env", envv(0), 50);
        mx = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (envv(0) > mx) mx = envv(0);
        end
        check("early_max", mx, 50);
        check("early_level", envv(0), 25);

        // retrigger during release at level 80
        bus.Gate = 4'b0001;
        cyc();
        run_until(0, 255, 700, n);
        run_until(0, 100, 400, n);
        cyc();
        bus.Gate = 4'b0000;
        cyc();
        run_until(0, 80, 200, n);
        check("retrig_reach80", n, 80);
        bus.Gate = 4'b0001;
        cyc();
        check("retrig_entry", envv(0), RETRIG0);
        cyc();
        cyc();
        check("retrig_step", envv(0), RETRIG0 + 1);

        // independence and frozen release on voice 2
        bus.Gate = 4'b0101;
        cyc();
        repeat (100) cyc();
        check("v2_attack", envv(2), 50);
        bus.ReleaseRate = 8'd0;
        bus.Gate = 4'b0001;
        cyc();
        repeat (50) cyc();
        check("freeze_env", envv(2), 50);
        check("freeze_active", bus.Active[2], 1);
        check("idle_v1", envv(1), 0);
        check("idle_v3", envv(3), 0);
        check("idle_act13", {bus.Active[3], bus.Active[1]}, 0);

        // reset mid-attack with gate held high
        bus.ReleaseRate = 8'd64;
        repeat (20) cyc();
        Reset = 1'b0;
        cyc();
        check("midreset_env", bus.Envelope, 0);
        check("midreset_active", bus.Active, 0);
        repeat (2) cyc();
        check("reset_hold_active", bus.Active, 0);
        Reset = 1'b1;
        cyc();
        check("rerise_active", bus.Active, 4'b0001);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int v = 0; v < NV; v++)
                if ($urandom_range(0, 39) == 0) bus.Gate[v] = ~bus.Gate[v];
            if ($urandom_range(0, 199) == 0) bus.AttackRate = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) bus.DecayRate = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) bus.ReleaseRate = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) bus.Sustain = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) bus.Sustain = 8'd255;
            Reset = ($urandom_range(0, 599) != 0);
            cyc();
        end
        Reset = 1'b1;

        @(negedge Clock);
        #1;
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
